// File: rtl/dfd_tt_dbm_trace_capture.sv
// Trigger-and-capture trace buffer fed by the debug bus mux output.
// A mask/match trigger freezes a circular capture, which then drains oldest-first.
module dfd_tt_dbm_trace_capture #(
    parameter int DEBUG_BUS_WIDTH = 64,
    parameter int DEPTH           = 16,
    parameter int PTR_WIDTH       = $clog2(DEPTH),
    parameter int CNT_WIDTH       = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DEBUG_BUS_WIDTH-1:0] debug_bus_in,
    input  logic                       arm,
    input  logic                       clear,
    input  logic [DEBUG_BUS_WIDTH-1:0] trig_mask,
    input  logic [DEBUG_BUS_WIDTH-1:0] trig_match,
    input  logic [CNT_WIDTH-1:0]       post_trig_cnt,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DEBUG_BUS_WIDTH-1:0] rd_data,
    output logic [1:0]                 state,
    output logic [CNT_WIDTH-1:0]       fill_level,
    output logic                       triggered
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL     = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] MAX_POST = CNT_WIDTH'(DEPTH - 1);

    logic [DEBUG_BUS_WIDTH-1:0] mem [DEPTH];

    state_t               st;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] fill;
    logic [CNT_WIDTH-1:0] post_rem;
    logic                 trig;

    logic                 hit;
    logic                 wr_en;
    logic                 pop;
    logic [PTR_WIDTH-1:0] wr_ptr_inc;
    logic [CNT_WIDTH-1:0] fill_inc;
    logic [CNT_WIDTH-1:0] eff_post;
    logic [PTR_WIDTH-1:0] rd_start;

    always_comb begin
        hit        = ((debug_bus_in ^ trig_match) & trig_mask) == '0;
        wr_en      = ((st == ARMED) || (st == POST)) && !clear;
        pop        = (st == DONE) && (fill != '0) && rd_ready;
        wr_ptr_inc = wr_ptr + 1'b1;
        fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
        eff_post   = (post_trig_cnt > MAX_POST) ? MAX_POST : post_trig_cnt;
        // Once wrapped, the slot after the final write holds the oldest sample.
        rd_start   = (fill_inc == FULL) ? wr_ptr_inc : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= debug_bus_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            post_rem <= '0;
            trig     <= 1'b0;
        end else if (clear) begin
            st       <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            post_rem <= '0;
            trig     <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (arm) begin
                        st     <= ARMED;
                        wr_ptr <= '0;
                        fill   <= '0;
                        trig   <= 1'b0;
                    end
                end
                ARMED: begin
                    wr_ptr <= wr_ptr_inc;
                    fill   <= fill_inc;
                    if (hit) begin
                        trig <= 1'b1;
                        if (eff_post == '0) begin
                            st     <= DONE;
                            rd_ptr <= rd_start;
                        end else begin
                            post_rem <= eff_post;
                            st       <= POST;
                        end
                    end
                end
                POST: begin
                    wr_ptr   <= wr_ptr_inc;
                    fill     <= fill_inc;
                    post_rem <= post_rem - 1'b1;
                    if (post_rem == CNT_WIDTH'(1)) begin
                        st     <= DONE;
                        rd_ptr <= rd_start;
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        fill   <= fill - 1'b1;
                        if (fill == CNT_WIDTH'(1)) begin
                            st <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign rd_valid   = (st == DONE) && (fill != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign state      = st;
    assign fill_level = fill;
    assign triggered  = trig;

endmodule

// File: tb/tb_dfd_tt_dbm_trace_capture.sv
// Directed bench for dfd_tt_dbm_trace_capture with hand-derived expectations.
module tb_dfd_tt_dbm_trace_capture;

    localparam int W  = 64;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  bus;
    logic          arm;
    logic          clear;
    logic [W-1:0]  mask;
    logic [W-1:0]  match;
    logic [CW-1:0] post;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic [1:0]    state;
    logic [CW-1:0] fill;
    logic          triggered;

    int compared   = 0;
    int mismatched = 0;

    dfd_tt_dbm_trace_capture #(
        .DEBUG_BUS_WIDTH(W),
        .DEPTH          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .debug_bus_in (bus),
        .arm          (arm),
        .clear        (clear),
        .trig_mask    (mask),
        .trig_match   (match),
        .post_trig_cnt(post),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .state        (state),
        .fill_level   (fill),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm, then stream an incrementing bus from start until DONE (bounded).
    task automatic capture(input logic [W-1:0] start, input logic [CW-1:0] pc,
                           input logic [W-1:0] m, input logic [W-1:0] mt);
        mask  = m;
        match = mt;
        post  = pc;
        arm   = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_state", state, 1);
        check("armed_fill", fill, 0);
        check("armed_trig", triggered, 0);
        bus = start;
        for (int i = 0; i < 200 && state != 2'd3; i++) begin
            tick();
            bus = bus + 1;
        end
        check("capture_done", state, 3);
        check("capture_trig", triggered, 1);
    endtask

    task automatic drain(input logic [W-1:0] first, input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, first + W'(i));
            check("drain_fill", fill, W'(n - i));
            tick();
        end
        rd_ready = 1'b0;
        check("drain_state", state, 0);
        check("drain_valid_end", rd_valid, 0);
        check("drain_fill_end", fill, 0);
    endtask

    initial begin
        int idx;
        reset    = 1'b1;
        bus      = '0;
        arm      = 1'b0;
        clear    = 1'b0;
        mask     = '0;
        match    = '0;
        post     = '0;
        rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_state", state, 0);
        check("rst_fill", fill, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_trig", triggered, 0);

        // Wrapped capture: trigger 0x5A, post 3, last 16 samples 0x4E..0x5D.
        capture(64'h0, 5'd3, 64'hFF, 64'h5A);
        check("t1_fill", fill, 16);
        check("t1_valid", rd_valid, 1);
        drain(64'h4E, 16);

        // No wrap: trigger on 3rd sample, post 2 -> samples 1..5.
        capture(64'h1, 5'd2, '1, 64'h3);
        check("t2_fill", fill, 5);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t2_arm_ignored_state", state, 3);
        check("t2_arm_ignored_fill", fill, 5);
        check("t2_arm_ignored_data", rd_data, 1);
        drain(64'h1, 5);

        // Post count 31 clamps to 15; readout with rd_ready toggling.
        capture(64'h100, 5'd31, 64'hFFF, 64'h105);
        check("t3_fill", fill, 16);
        idx = 0;
        for (int k = 0; k < 64 && state == 2'd3; k++) begin
            rd_ready = (k % 2) == 0;
            check("t3_data", rd_data, 64'h105 + W'(idx));
            check("t3_valid", rd_valid, 1);
            tick();
            if (rd_ready) idx++;
        end
        rd_ready = 1'b0;
        check("t3_count", W'(idx), 16);
        check("t3_state", state, 0);
        check("t3_valid_end", rd_valid, 0);

        // clear together with arm in POST.
        mask  = 64'hFF;
        match = 64'h3;
        post  = 5'd10;
        arm   = 1'b1;
        tick();
        arm = 1'b0;
        bus = '0;
        for (int i = 0; i < 50 && state != 2'd2; i++) begin
            tick();
            bus = bus + 1;
        end
        check("t5_post", state, 2);
        check("t5_fill_trig", fill, 4);
        tick();
        bus = bus + 1;
        check("t5_fill_post", fill, 5);
        clear    = 1'b1;
        arm      = 1'b1;
        rd_ready = 1'b1;
        tick();
        clear    = 1'b0;
        arm      = 1'b0;
        rd_ready = 1'b0;
        check("t5_state", state, 0);
        check("t5_fill", fill, 0);
        check("t5_trig", triggered, 0);
        check("t5_valid", rd_valid, 0);
        tick();
        check("t5_stay_idle", state, 0);
        check("t5_stay_invalid", rd_valid, 0);

        // Fresh capture, mask 0: trigger on first sample, post 0.
        capture(64'hABCD, 5'd0, '0, '1);
        check("t7_fill", fill, 1);
        drain(64'hABCD, 1);

        // Async reset in DONE with 7 entries.
        capture(64'h1, 5'd0, '1, 64'h7);
        check("t6_fill", fill, 7);
        check("t6_data", rd_data, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_state", state, 0);
        check("t6_rst_fill", fill, 0);
        check("t6_rst_valid", rd_valid, 0);
        check("t6_rst_data", rd_data, 0);
        check("t6_rst_trig", triggered, 0);
        #1;
        reset = 1'b0;
        tick();
        check("t6_post_rst_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
